// File: rtl/cp0_seq_ctrl.sv
// CP0 sequencing controller: MFC0-after-MTC0 hazard stall, SYSCALL/interrupt traps
// and ERET returns, with all pipeline-control outputs taken straight from flops.
module cp0_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_cp0op,
  input  logic [2:0]  mem_cp0op,
  input  logic [4:0]  ex_cs,
  input  logic [4:0]  mem_cs,
  input  logic [2:0]  ex_sel,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] ex_pc,
  input  logic        ex_valid,
  input  logic        int_req,
  input  logic        status_ie,
  output logic [1:0]  cp0bubble,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [4:0]  cause_code,
  output logic        exl
);

  localparam logic [2:0]  OP_MFC0    = 3'd1;
  localparam logic [2:0]  OP_MTC0    = 3'd2;
  localparam logic [2:0]  OP_SYSCALL = 3'd3;
  localparam logic [2:0]  OP_ERET    = 3'd4;

  localparam logic [1:0]  BUB_PASS  = 2'd0;
  localparam logic [1:0]  BUB_FRONT = 2'd1;
  localparam logic [1:0]  BUB_HOLD  = 2'd2;
  localparam logic [1:0]  BUB_FLUSH = 2'd3;

  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0800;
  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [4:0]  EXC_SYS     = 5'd8;

  typedef enum logic [2:0] {S_IDLE, S_HAZ, S_TRAP, S_TRAP_HOLD, S_RET} state_t;

  state_t      state, next_state;
  logic [1:0]  bubble_nxt;
  logic        redirect_nxt;
  logic [31:0] redirect_pc_nxt;

  logic take_sys, take_eret, take_int, take_haz, trap_entry;

  // Candidate events; priority is resolved in the next-state logic.
  assign take_sys  = (ex_cp0op == OP_SYSCALL);
  assign take_eret = (ex_cp0op == OP_ERET);
  assign take_int  = int_req & status_ie & ~exl;
  assign take_haz  = (ex_cp0op == OP_MFC0) && (mem_cp0op == OP_MTC0) &&
                     (ex_cs == mem_cs) && (ex_sel == mem_sel);

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE: begin
        if (ex_valid) begin
          if (take_sys)       next_state = S_TRAP;
          else if (take_eret) next_state = S_RET;
          else if (take_int)  next_state = S_TRAP;
          else if (take_haz)  next_state = S_HAZ;
        end
      end
      S_HAZ:       next_state = S_IDLE;
      S_TRAP:      next_state = S_TRAP_HOLD;
      S_TRAP_HOLD: next_state = S_IDLE;
      S_RET:       next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered alongside it.
  always_comb begin
    bubble_nxt      = BUB_PASS;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = redirect_pc;
    case (next_state)
      S_HAZ:       bubble_nxt = BUB_FRONT;
      S_TRAP: begin
        bubble_nxt      = BUB_FLUSH;
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = TRAP_VECTOR;
      end
      S_TRAP_HOLD: bubble_nxt = BUB_HOLD;
      S_RET: begin
        bubble_nxt      = BUB_FLUSH;
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = epc;
      end
      default: ;
    endcase
  end

  assign trap_entry = (state == S_IDLE) && (next_state == S_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state       <= S_IDLE;
      cp0bubble   <= BUB_PASS;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      epc         <= '0;
      cause_code  <= '0;
      exl         <= 1'b0;
    end else begin
      state       <= next_state;
      cp0bubble   <= bubble_nxt;
      pc_redirect <= redirect_nxt;
      redirect_pc <= redirect_pc_nxt;
      if (trap_entry) begin
        epc        <= ex_pc;
        cause_code <= take_sys ? EXC_SYS : EXC_INT;
        exl        <= 1'b1;
      end else if (state == S_RET) begin
        exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_seq_ctrl.sv
// Self-checking bench for cp0_seq_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a schedule-queue reference model.
module tb_cp0_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ex_cp0op, mem_cp0op, ex_sel, mem_sel;
  logic [4:0]  ex_cs, mem_cs;
  logic [31:0] ex_pc;
  logic        ex_valid, int_req, status_ie;
  logic [1:0]  cp0bubble;
  logic        pc_redirect;
  logic [31:0] redirect_pc, epc;
  logic [4:0]  cause_code;
  logic        exl;

  int n_checks = 0;
  int n_err    = 0;

  cp0_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_cp0op(ex_cp0op), .mem_cp0op(mem_cp0op),
    .ex_cs(ex_cs), .mem_cs(mem_cs), .ex_sel(ex_sel), .mem_sel(mem_sel),
    .ex_pc(ex_pc), .ex_valid(ex_valid), .int_req(int_req), .status_ie(status_ie),
    .cp0bubble(cp0bubble), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .epc(epc), .cause_code(cause_code), .exl(exl)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted event schedules the output pattern of each
  // upcoming cycle; an empty schedule means the controller is idle.
  typedef struct {
    logic [1:0]  bub;
    logic        red;
    logic [31:0] tgt;
    logic        clr_exl;
  } slot_t;

  slot_t       sched[$];
  logic [31:0] m_epc, m_rpc;
  logic [4:0]  m_cause;
  logic        m_exl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_trap(input logic [4:0] code);
    slot_t s;
    m_epc   = ex_pc;
    m_cause = code;
    m_exl   = 1'b1;
    s = '{bub: 2'd3, red: 1'b1, tgt: 32'h0000_0800, clr_exl: 1'b0};
    sched.push_back(s);
    s = '{bub: 2'd2, red: 1'b0, tgt: 32'h0, clr_exl: 1'b0};
    sched.push_back(s);
  endtask

  task automatic model_edge();
    slot_t s;
    if (rst) begin
      sched.delete();
      m_epc = '0; m_rpc = '0; m_cause = '0; m_exl = 1'b0;
    end else if (sched.size() != 0) begin
      s = sched.pop_front();
      if (s.clr_exl) m_exl = 1'b0;
    end else if (ex_valid) begin
      if (ex_cp0op == 3'd3) model_trap(5'd8);
      else if (ex_cp0op == 3'd4) begin
        s = '{bub: 2'd3, red: 1'b1, tgt: m_epc, clr_exl: 1'b1};
        sched.push_back(s);
      end else if (int_req && status_ie && !m_exl) model_trap(5'd0);
      else if (ex_cp0op == 3'd1 && mem_cp0op == 3'd2 &&
               ex_cs == mem_cs && ex_sel == mem_sel) begin
        s = '{bub: 2'd1, red: 1'b0, tgt: 32'h0, clr_exl: 1'b0};
        sched.push_back(s);
      end
    end
    if (sched.size() != 0 && sched[0].red) m_rpc = sched[0].tgt;
  endtask

  task automatic compare_all(input string tag);
    logic [1:0] eb;
    logic       er;
    eb = (sched.size() != 0) ? sched[0].bub : 2'd0;
    er = (sched.size() != 0) ? sched[0].red : 1'b0;
    check({tag, ".bubble"},   {30'd0, cp0bubble},    {30'd0, eb});
    check({tag, ".redirect"}, {31'd0, pc_redirect},  {31'd0, er});
    check({tag, ".rpc"},      redirect_pc,           m_rpc);
    check({tag, ".epc"},      epc,                   m_epc);
    check({tag, ".cause"},    {27'd0, cause_code},   {27'd0, m_cause});
    check({tag, ".exl"},      {31'd0, exl},          {31'd0, m_exl});
  endtask

  // Inputs are applied 1 time unit after a rising edge and sampled by the DUT at the next.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic r, input logic [2:0] eop, input logic [2:0] mop,
                        input logic [4:0] ecs, input logic [4:0] mcs,
                        input logic [2:0] esel, input logic [2:0] msel,
                        input logic [31:0] pc, input logic v, input logic irq,
                        input logic ie);
    rst = r; ex_cp0op = eop; mem_cp0op = mop; ex_cs = ecs; mem_cs = mcs;
    ex_sel = esel; mem_sel = msel; ex_pc = pc; ex_valid = v; int_req = irq; status_ie = ie;
  endtask

  task automatic idle_in();
    set_in(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    m_epc = '0; m_rpc = '0; m_cause = '0; m_exl = 1'b0;
    set_in(1'b1, 3'd0, 3'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("reset0");
    tick("reset1");
    check("reset_bubble", {30'd0, cp0bubble}, 32'd0);
    check("reset_epc", epc, 32'd0);

    // SYSCALL at 0x40 on the first edge out of reset
    set_in(1'b0, 3'd3, 3'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
    tick("sys");
    check("sys_bubble", {30'd0, cp0bubble}, 32'd3);
    check("sys_rpc", redirect_pc, 32'h0000_0800);
    check("sys_epc", epc, 32'h0000_0040);
    check("sys_cause", {27'd0, cause_code}, 32'd8);
    idle_in();
    tick("sys_hold");
    check("sys_hold_bubble", {30'd0, cp0bubble}, 32'd2);
    tick("sys_done");
    check("sys_done_bubble", {30'd0, cp0bubble}, 32'd0);

    // ERET back to epc, exl drops after the return cycle
    set_in(1'b0, 3'd4, 3'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    tick("eret");
    check("eret_rpc", redirect_pc, 32'h0000_0040);
    check("eret_redirect", {31'd0, pc_redirect}, 32'd1);
    idle_in();
    tick("eret_done");
    check("eret_exl", {31'd0, exl}, 32'd0);

    // MFC0 after MTC0 on the same register: one stall cycle; different cs: none
    set_in(1'b0, 3'd1, 3'd2, 5'd12, 5'd12, 3'd0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick("haz");
    check("haz_bubble", {30'd0, cp0bubble}, 32'd1);
    tick("haz_once");
    check("haz_once_bubble", {30'd0, cp0bubble}, 32'd0);
    ex_cs = 5'd13;
    tick("nohaz");
    check("nohaz_bubble", {30'd0, cp0bubble}, 32'd0);

    // SYSCALL beats a concurrent interrupt; held int_req is masked while exl=1
    set_in(1'b0, 3'd3, 3'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
    tick("sys_int");
    check("sys_int_cause", {27'd0, cause_code}, 32'd8);
    ex_cp0op = 3'd0;
    for (int i = 0; i < 5; i++) tick("int_masked");
    check("int_masked_bubble", {30'd0, cp0bubble}, 32'd0);

    // ERET clears exl, then the still-pending interrupt is taken
    ex_cp0op = 3'd4;
    tick("eret2");
    ex_cp0op = 3'd0; ex_pc = 32'h0000_0300;
    tick("eret2_done");
    tick("int_taken");
    check("int_cause", {27'd0, cause_code}, 32'd0);
    check("int_epc", epc, 32'h0000_0300);

    // Reset in the middle of a trap
    idle_in();
    tick("settle0");
    tick("settle1");
    set_in(1'b0, 3'd3, 3'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'h0000_0444, 1'b1, 1'b0, 1'b0);
    tick("sys3");
    rst = 1'b1;
    tick("rst_mid");
    check("rst_mid_bubble", {30'd0, cp0bubble}, 32'd0);
    check("rst_mid_exl", {31'd0, exl}, 32'd0);
    rst = 1'b0; ex_cp0op = 3'd0;
    tick("rst_after");

    // Randomized traffic with narrow cs/sel ranges so hazards actually occur
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 59) == 0),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 2)),
             5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
             3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
             $urandom & 32'hFFFF_FFFC,
             ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 0));
      if (ex_cp0op == 3'd3 && $urandom_range(0, 2) != 0) ex_cp0op = 3'd0;
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_seq_ctrl.md
CP0_SEQ_CTRL -- requirements
Module: cp0_seq_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; ports listed below, clock and reset first.
REQ-002 clk  in  1  pipeline clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 ex_cp0op  in  3  CP0 op in EX: 0 none, 1 MFC0, 2 MTC0, 3 SYSCALL, 4 ERET, 5-7 treated as none.
REQ-005 mem_cp0op  in  3  CP0 op currently held in EX/MEM register, same encoding.
REQ-006 ex_cs / mem_cs  in  5 each  CP0 register number in EX / MEM.
REQ-007 ex_sel / mem_sel  in  3 each  CP0 select field in EX / MEM.
REQ-008 ex_pc  in  32  PC of the instruction in EX.
REQ-009 ex_valid  in  1  EX holds a real (non-bubble) instruction.
REQ-010 int_req  in  1  level external interrupt request.
REQ-011 status_ie  in  1  global interrupt enable from CP0 Status.
REQ-012 cp0bubble  out  2  pipeline-register control: 0 pass, 1 front stall (PC/IF-ID/ID-EX hold, bubble into EX/MEM), 2 hold EX/MEM and clear its cp0op, 3 flush IF-ID/ID-EX/EX-MEM.
REQ-013 pc_redirect  out  1  one-cycle strobe: load redirect_pc into PC.
REQ-014 redirect_pc  out  32  redirect target.
REQ-015 epc  out  32  exception PC register.
REQ-016 cause_code  out  5  ExcCode: 0 interrupt, 8 syscall.
REQ-017 exl  out  1  exception level flag.

Function
REQ-018 SHALL be a registered FSM with states IDLE, HAZ, TRAP, TRAP_HOLD, RET; all outputs driven from registers (no combinational input-to-output path).
REQ-019 IDLE: cp0bubble=0, pc_redirect=0.
REQ-020 From IDLE, with ex_valid=1, priority SYSCALL > ERET > interrupt > hazard; one event per cycle, lower-priority events dropped.
REQ-021 SYSCALL (ex_cp0op=3) -> TRAP; epc<=ex_pc, cause_code<=8, exl<=1 on same edge.
REQ-022 ERET (ex_cp0op=4) -> RET; ERET with exl=0 still executes (redirect to current epc).
REQ-023 Interrupt (int_req & status_ie & ~exl & ex_cp0op∈{0,1,2,5-7}) -> TRAP; epc<=ex_pc, cause_code<=0, exl<=1.
REQ-024 Hazard: ex_cp0op=1 & mem_cp0op=2 & ex_cs==mem_cs & ex_sel==mem_sel -> HAZ.
REQ-025 HAZ: cp0bubble=1 for exactly one cycle, then IDLE unconditionally; events in that cycle ignored.
REQ-026 TRAP: cp0bubble=3, pc_redirect=1, redirect_pc=32'h0000_0800, one cycle, then TRAP_HOLD.
REQ-027 TRAP_HOLD: cp0bubble=2, pc_redirect=0, one cycle, then IDLE.
REQ-028 RET: cp0bubble=3, pc_redirect=1, redirect_pc=epc, exl<=0 on exit edge, one cycle, then IDLE.
REQ-029 Events arriving in TRAP, TRAP_HOLD or RET SHALL be ignored (not queued); int_req held high re-evaluated only in IDLE and masked by exl.
REQ-030 ex_valid=0 SHALL suppress every transition out of IDLE.
REQ-031 epc and cause_code SHALL change only on TRAP entry; redirect_pc holds its value outside redirect cycles.

Reset
REQ-032 rst=1 at posedge clk SHALL force state=IDLE, cp0bubble=0, pc_redirect=0, redirect_pc=0, epc=0, cause_code=0, exl=0, regardless of current state, including mid-TRAP/RET.
REQ-033 First event accepted on the first edge with rst=0.

Verification
REQ-034 Reset; ex_valid=1, ex_cp0op=3, ex_pc=32'h0000_0040 -> next cycle cp0bubble=3, pc_redirect=1, redirect_pc=32'h0000_0800, epc=32'h0000_0040, cause_code=8, exl=1; next cycle cp0bubble=2; then 0.
REQ-035 exl=1, epc=32'h0000_0040, ex_cp0op=4 -> one cycle cp0bubble=3, pc_redirect=1, redirect_pc=32'h0000_0040; then exl=0, cp0bubble=0.
REQ-036 mem_cp0op=2, ex_cp0op=1, cs=12, sel=0 both -> cp0bubble=1 exactly one cycle; repeat with ex_cs=13 -> cp0bubble stays 0.
REQ-037 int_req=1, status_ie=1, ex_cp0op=3 same cycle -> cause_code=8 (syscall wins); int_req held through TRAP_HOLD -> no second trap while exl=1.
REQ-038 rst asserted during TRAP cycle -> next cycle all outputs at reset values, state IDLE.
